multi_fetch_icache: RTL and testbench
=====================================

MULTI_FETCH_ICACHE -- requirements
Module: multi_fetch_icache

Interface
REQ-001 The block SHALL have parameter FETCH_WIDTH, default 2, giving instructions returned per fetch (1..LINE_WORDS).
REQ-002 The block SHALL have parameter LINE_WORDS, default 4, giving 32-bit words per cache line (power of 2, >=2).
REQ-003 The block SHALL have parameter NUM_LINES, default 64, giving direct-mapped line count (power of 2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 fetch_req  input  1  fetch request; accepted when fetch_ready=1.
REQ-007 fetch_pc  input  32  byte address of first instruction; bits [1:0] ignored.
REQ-008 fetch_ready  output  1  cache can accept a request this cycle.
REQ-009 fetch_valid  output  1  one-cycle pulse marking a valid response.
REQ-010 instr_out  output  FETCH_WIDTH x 32  instructions, lane 0 at fetch_pc.
REQ-011 pc_out  output  FETCH_WIDTH x 32  lane n = fetch_pc + 4n.
REQ-012 lane_valid  output  FETCH_WIDTH  per-lane valid mask.
REQ-013 flush  input  1  invalidate all lines.
REQ-014 mem_req / mem_addr / mem_ready  output / output 32 / input 1  refill request handshake; transfer when mem_req and mem_ready both high.
REQ-015 mem_rvalid / mem_rdata  input 1 / input 32  one refill word per beat, in ascending address order.

Function
REQ-016 Address split SHALL be: offset = pc[2 +: log2(LINE_WORDS)], index = next log2(NUM_LINES) bits, tag = remaining upper bits.
REQ-017 FSM states SHALL be IDLE, MISS_REQ, REFILL, RESPOND.
REQ-018 IDLE: fetch_ready=1; an accepted request that hits (valid and tag match) SHALL produce fetch_valid=1 with data on the next cycle (1-cycle latency); back-to-back hits SHALL sustain one response per cycle.
REQ-019 IDLE: an accepted miss SHALL latch fetch_pc, drop fetch_ready, and enter MISS_REQ.
REQ-020 MISS_REQ: mem_req=1 and mem_addr = line-aligned latched pc SHALL hold stable until mem_ready=1, then enter REFILL.
REQ-021 REFILL: each mem_rvalid beat SHALL write word k (k = 0..LINE_WORDS-1) into the line; after the last beat the tag and valid bit SHALL be written and the FSM SHALL enter RESPOND.
REQ-022 RESPOND: outputs for the latched pc SHALL appear with fetch_valid=1 for one cycle, then the FSM SHALL return to IDLE.
REQ-023 Lane n SHALL be valid iff offset+n < LINE_WORDS; a bundle never crosses a line boundary, and invalid lanes SHALL drive instr_out=0.
REQ-024 pc_out arithmetic SHALL be 32-bit unsigned modulo 2^32.
REQ-025 flush SHALL clear all valid bits at the next edge; a flush together with a hit in IDLE SHALL suppress that response (fetch_valid=0).
REQ-026 flush during MISS_REQ or REFILL SHALL still complete the address handshake and drain all LINE_WORDS beats, but SHALL NOT set the valid bit and SHALL skip RESPOND, going straight to IDLE.
REQ-027 mem_rvalid outside REFILL SHALL be ignored.
REQ-028 fetch_valid SHALL be 0 in every cycle without a response.

Reset
REQ-029 reset low SHALL asynchronously force: FSM=IDLE, all valid bits=0, fetch_valid=0, lane_valid=0, mem_req=0, mem_addr=0, instr_out=0, pc_out=0, and beat counter=0.
REQ-030 Reset mid-refill SHALL abandon the refill; the line SHALL remain invalid.
REQ-031 Data and tag arrays are not reset.

Structure
REQ-032 Package icache_pkg SHALL hold the FSM state enum, the default parameter values, and address-split width functions.
REQ-033 Sub-module icache_line_store SHALL hold the tag, valid, and data arrays, with one read port (a full line) and one word-write port.

Verification (FETCH_WIDTH=2, LINE_WORDS=4, NUM_LINES=64)
REQ-034 Cold fetch 0x100, mem_ready=1, beats 0xA0..0xA3 -> mem_addr=0x100; after the last beat, fetch_valid with instr_out={0xA0,0xA1}, pc_out={0x100,0x104}, lane_valid=2'b11.
REQ-035 Then fetch 0x108 and 0x10C back-to-back -> hits on consecutive cycles: {0xA2,0xA3} mask 11, then {0xA3,0} mask 01.
REQ-036 Fetch 0x500 (same index, different tag as 0x100) -> miss and refill; a subsequent fetch 0x100 misses again.
REQ-037 flush asserted on the second refill beat -> all 4 beats consumed, no fetch_valid, and a refetch of the same pc misses.
REQ-038 reset pulsed low during REFILL -> outputs zero immediately; after release, fetch_ready=1 and the same pc misses.
REQ-039 mem_ready held low 5 cycles -> mem_req and mem_addr stable all 5 cycles, and fetch_ready=0 throughout.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared FSM encoding, default sizing and address-split width helpers
// for the multi-fetch instruction cache.
package icache_pkg;

    localparam int unsigned DEF_FETCH_WIDTH = 2;
    localparam int unsigned DEF_LINE_WORDS  = 4;
    localparam int unsigned DEF_NUM_LINES   = 64;

    typedef enum logic [1:0] {
        IDLE,
        MISS_REQ,
        REFILL,
        RESPOND
    } icache_state_t;

    function automatic int unsigned offset_width(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned index_width(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    // Byte-offset bits [1:0] are never part of the tag.
    function automatic int unsigned tag_width(input int unsigned line_words,
                                              input int unsigned num_lines);
        return 32 - 2 - offset_width(line_words) - index_width(num_lines);
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Direct-mapped tag/valid/data storage: one full-line read port and one
// word-write port; tag and valid bit are committed by fill_en.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
    parameter int unsigned NUM_LINES  = DEF_NUM_LINES,
    parameter int unsigned OFF_W      = offset_width(DEF_LINE_WORDS),
    parameter int unsigned IDX_W      = index_width(DEF_NUM_LINES),
    parameter int unsigned TAG_W      = tag_width(DEF_LINE_WORDS, DEF_NUM_LINES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [IDX_W-1:0]            rd_index,
    output logic [LINE_WORDS-1:0][31:0] rd_line,
    output logic [TAG_W-1:0]            rd_tag,
    output logic                        rd_valid,
    input  logic                        wr_en,
    input  logic [IDX_W-1:0]            wr_index,
    input  logic [OFF_W-1:0]            wr_word,
    input  logic [31:0]                 wr_data,
    input  logic                        fill_en,
    input  logic [TAG_W-1:0]            fill_tag,
    input  logic                        invalidate_all
);

    logic [LINE_WORDS-1:0][31:0] data_mem [NUM_LINES];
    logic [TAG_W-1:0]            tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0]        valid_q;

    // Data and tags are deliberately unreset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_index][wr_word] <= wr_data;
        end
        if (fill_en) begin
            tag_mem[wr_index] <= fill_tag;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            if (invalidate_all) begin
                valid_q <= '0;
            end
            if (fill_en) begin
                valid_q[wr_index] <= 1'b1;
            end
        end
    end

    assign rd_line  = data_mem[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid_q[rd_index];

endmodule

// File: rtl/multi_fetch_icache.sv
// Direct-mapped instruction cache returning FETCH_WIDTH instructions per
// fetch; misses refill a whole line over a beat-per-word memory interface.
module multi_fetch_icache
    import icache_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH = DEF_FETCH_WIDTH,
    parameter int unsigned LINE_WORDS  = DEF_LINE_WORDS,
    parameter int unsigned NUM_LINES   = DEF_NUM_LINES
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         fetch_req,
    input  logic [31:0]                  fetch_pc,
    output logic                         fetch_ready,
    output logic                         fetch_valid,
    output logic [FETCH_WIDTH-1:0][31:0] instr_out,
    output logic [FETCH_WIDTH-1:0][31:0] pc_out,
    output logic [FETCH_WIDTH-1:0]       lane_valid,
    input  logic                         flush,
    output logic                         mem_req,
    output logic [31:0]                  mem_addr,
    input  logic                         mem_ready,
    input  logic                         mem_rvalid,
    input  logic [31:0]                  mem_rdata
);

    localparam int unsigned      OFF_W     = offset_width(LINE_WORDS);
    localparam int unsigned      IDX_W     = index_width(NUM_LINES);
    localparam int unsigned      TAG_W     = tag_width(LINE_WORDS, NUM_LINES);
    localparam logic [31:0]      LINE_MASK = 32'(LINE_WORDS * 4 - 1);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    icache_state_t state, state_nx;

    logic [31:0]                  miss_pc;
    logic [31:0]                  lookup_pc;
    logic [OFF_W-1:0]             lookup_off;
    logic [OFF_W-1:0]             beat_cnt;
    logic                         flush_seen;
    logic [LINE_WORDS-1:0][31:0]  rd_line;
    logic [TAG_W-1:0]             rd_tag;
    logic                         rd_valid;
    logic                         hit;
    logic                         last_beat;
    logic                         drop_fill;
    logic                         beat_wr;
    logic                         fill_en;
    logic                         resp_fire;
    logic                         miss_accept;
    logic [FETCH_WIDTH-1:0][31:0] instr_nx;
    logic [FETCH_WIDTH-1:0][31:0] pc_nx;
    logic [FETCH_WIDTH-1:0]       lane_nx;

    // RESPOND re-reads the freshly filled line through the same read port.
    assign lookup_pc  = (state == RESPOND) ? miss_pc : fetch_pc;
    assign lookup_off = lookup_pc[2 +: OFF_W];
    assign hit        = rd_valid && (rd_tag == lookup_pc[31 -: TAG_W]);
    assign last_beat  = (beat_cnt == LAST_BEAT);
    assign drop_fill  = flush_seen || flush;
    assign beat_wr    = (state == REFILL) && mem_rvalid;
    assign fill_en    = beat_wr && last_beat && !drop_fill;

    icache_line_store #(
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES),
        .OFF_W      (OFF_W),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_store (
        .clk            (clk),
        .reset          (reset),
        .rd_index       (lookup_pc[2 + OFF_W +: IDX_W]),
        .rd_line        (rd_line),
        .rd_tag         (rd_tag),
        .rd_valid       (rd_valid),
        .wr_en          (beat_wr),
        .wr_index       (miss_pc[2 + OFF_W +: IDX_W]),
        .wr_word        (beat_cnt),
        .wr_data        (mem_rdata),
        .fill_en        (fill_en),
        .fill_tag       (miss_pc[31 -: TAG_W]),
        .invalidate_all (flush)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        fetch_ready = 1'b0;
        mem_req     = 1'b0;
        resp_fire   = 1'b0;
        miss_accept = 1'b0;
        case (state)
            IDLE: begin
                fetch_ready = 1'b1;
                if (fetch_req) begin
                    if (hit) begin
                        resp_fire = !flush;
                    end else begin
                        miss_accept = 1'b1;
                        state_nx    = MISS_REQ;
                    end
                end
            end
            MISS_REQ: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_nx = REFILL;
                end
            end
            REFILL: begin
                if (mem_rvalid && last_beat) begin
                    state_nx = drop_fill ? IDLE : RESPOND;
                end
            end
            RESPOND: begin
                resp_fire = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Lanes past the end of the line are masked so a bundle never spans lines.
    always_comb begin
        instr_nx = '0;
        pc_nx    = '0;
        lane_nx  = '0;
        for (int unsigned n = 0; n < FETCH_WIDTH; n++) begin
            pc_nx[n] = lookup_pc + 32'(4 * n);
            if (32'(lookup_off) + n < LINE_WORDS) begin
                lane_nx[n]  = 1'b1;
                instr_nx[n] = rd_line[lookup_off + OFF_W'(n)];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_pc     <= '0;
            mem_addr    <= '0;
            beat_cnt    <= '0;
            flush_seen  <= 1'b0;
            fetch_valid <= 1'b0;
            lane_valid  <= '0;
            instr_out   <= '0;
            pc_out      <= '0;
        end else begin
            fetch_valid <= resp_fire;
            lane_valid  <= resp_fire ? lane_nx : '0;
            if (resp_fire) begin
                instr_out <= instr_nx;
                pc_out    <= pc_nx;
            end
            if (miss_accept) begin
                miss_pc  <= fetch_pc;
                mem_addr <= fetch_pc & ~LINE_MASK;
            end
            if (beat_wr) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            // A flush seen mid-miss poisons the fill until the FSM is idle again.
            if (state_nx == IDLE) begin
                flush_seen <= 1'b0;
            end else if (flush && (state == MISS_REQ || state == REFILL)) begin
                flush_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multi_fetch_icache.sv
// Scoreboard bench for multi_fetch_icache: stimulus pushes expected responses,
// a monitor pops and compares whenever fetch_valid is seen.
module tb_multi_fetch_icache;

    logic             clk        = 1'b0;
    logic             reset      = 1'b0;
    logic             fetch_req  = 1'b0;
    logic [31:0]      fetch_pc   = '0;
    logic             flush      = 1'b0;
    logic             mem_ready  = 1'b0;
    logic             mem_rvalid = 1'b0;
    logic [31:0]      mem_rdata  = '0;
    logic             fetch_ready;
    logic             fetch_valid;
    logic [1:0][31:0] instr_out;
    logic [1:0][31:0] pc_out;
    logic [1:0]       lane_valid;
    logic             mem_req;
    logic [31:0]      mem_addr;

    typedef struct {
        logic [31:0] i0;
        logic [31:0] i1;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [1:0]  lv;
    } resp_t;

    resp_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    multi_fetch_icache #(
        .FETCH_WIDTH (2),
        .LINE_WORDS  (4),
        .NUM_LINES   (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .lane_valid  (lane_valid),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] i0,
                        input logic [31:0] i1, input logic [1:0] lv);
        resp_t e;
        e.i0 = i0;
        e.i1 = i1;
        e.p0 = pc;
        e.p1 = pc + 32'd4;
        e.lv = lv;
        exp_q.push_back(e);
    endtask

    // Issue a fetch expected to miss, hold mem_ready low for wait_cycles, then handshake.
    task automatic start_miss(input logic [31:0] pc, input int wait_cycles, input string tag);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        mem_ready = 1'b0;
        cyc();
        fetch_req = 1'b0;
        for (int w = 0; w < wait_cycles; w++) begin
            chk({tag, "_wait_mem_req"}, 32'(mem_req), 32'd1);
            chk({tag, "_wait_mem_addr"}, mem_addr, pc & ~32'hF);
            chk({tag, "_wait_fetch_ready"}, 32'(fetch_ready), 32'd0);
            cyc();
        end
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_mem_addr"}, mem_addr, pc & ~32'hF);
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        chk({tag, "_mem_req_drop"}, 32'(mem_req), 32'd0);
    endtask

    task automatic beats(input logic [31:0] d0, input int n, input int flush_at);
        for (int k = 0; k < n; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = d0 + 32'(k);
            flush      = (k == flush_at);
            cyc();
        end
        mem_rvalid = 1'b0;
        flush      = 1'b0;
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset && fetch_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_response: got pc %h, expected no response", pc_out[0]);
                end else begin
                    resp_t e;
                    e = exp_q.pop_front();
                    chk("resp_instr0", instr_out[0], e.i0);
                    chk("resp_instr1", instr_out[1], e.i1);
                    chk("resp_pc0", pc_out[0], e.p0);
                    chk("resp_pc1", pc_out[1], e.p1);
                    chk("resp_lane_valid", 32'(lane_valid), 32'(e.lv));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        cyc();
        cyc();
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_lane_valid", 32'(lane_valid), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_instr_out", instr_out[0] | instr_out[1], 32'd0);
        chk("rst_pc_out", pc_out[0] | pc_out[1], 32'd0);
        reset = 1'b1;
        cyc();
        chk("rst_release_ready", 32'(fetch_ready), 32'd1);

        // Cold miss at 0x100
        push(32'h100, 32'hA0, 32'hA1, 2'b11);
        start_miss(32'h100, 0, "cold");
        beats(32'hA0, 4, -1);
        cyc();
        cyc();

        // Stray read beats while idle must not disturb the line
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        cyc();
        cyc();
        mem_rvalid = 1'b0;

        // Back-to-back hits, second one crossing into the masked lane
        push(32'h108, 32'hA2, 32'hA3, 2'b11);
        push(32'h10C, 32'hA3, 32'h0, 2'b01);
        fetch_req = 1'b1;
        fetch_pc  = 32'h108;
        cyc();
        chk("hit1_valid", 32'(fetch_valid), 32'd1);
        fetch_pc = 32'h10C;
        cyc();
        chk("hit2_valid", 32'(fetch_valid), 32'd1);
        fetch_req = 1'b0;
        cyc();
        chk("idle_no_valid", 32'(fetch_valid), 32'd0);

        // Conflict miss at 0x500 with mem_ready held off for 5 cycles
        push(32'h500, 32'hB0, 32'hB1, 2'b11);
        start_miss(32'h500, 5, "conflict");
        beats(32'hB0, 4, -1);
        cyc();
        cyc();

        // 0x100 was evicted
        push(32'h100, 32'hC0, 32'hC1, 2'b11);
        start_miss(32'h100, 0, "evicted");
        beats(32'hC0, 4, -1);
        cyc();
        cyc();

        // Flush on second refill beat: drain all beats, no response
        start_miss(32'h200, 0, "flushfill");
        beats(32'hD0, 4, 1);
        chk("flushfill_ready", 32'(fetch_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("flushfill_no_valid", 32'(fetch_valid), 32'd0);
            cyc();
        end
        push(32'h200, 32'hE0, 32'hE1, 2'b11);
        start_miss(32'h200, 0, "flush_refetch");
        beats(32'hE0, 4, -1);
        cyc();
        cyc();

        // Flush together with a hit suppresses the response and invalidates
        fetch_req = 1'b1;
        fetch_pc  = 32'h208;
        flush     = 1'b1;
        cyc();
        fetch_req = 1'b0;
        flush     = 1'b0;
        chk("flush_hit_suppressed", 32'(fetch_valid), 32'd0);
        push(32'h208, 32'hF2, 32'hF3, 2'b11);
        start_miss(32'h208, 0, "post_flush");
        beats(32'hF0, 4, -1);
        cyc();
        cyc();

        // Reset in the middle of a refill
        start_miss(32'h300, 0, "rstfill");
        beats(32'h11, 2, -1);
        reset = 1'b0;
        #1;
        chk("midrst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("midrst_lane_valid", 32'(lane_valid), 32'd0);
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        chk("midrst_instr0", instr_out[0], 32'd0);
        chk("midrst_instr1", instr_out[1], 32'd0);
        chk("midrst_pc0", pc_out[0], 32'd0);
        chk("midrst_pc1", pc_out[1], 32'd0);
        cyc();
        reset = 1'b1;
        cyc();
        chk("midrst_ready", 32'(fetch_ready), 32'd1);
        push(32'h300, 32'h20, 32'h21, 2'b11);
        start_miss(32'h300, 0, "rst_refetch");
        beats(32'h20, 4, -1);
        cyc();
        cyc();

        cyc();
        cyc();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
